// File: rtl/ps2_pkg.sv
// Shared PS/2 protocol constants, frame-state encoding and the parity helper
// used by the receive path and the key decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Odd parity holds when the data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises and debounces the raw lines,
// shifts in start/8 data/parity/stop and reports a byte or a frame error.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       timeout_o
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        clk_sync_q, dat_sync_q;
  logic              fclk_q, fclk_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              strobe_q, strobe_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_q, timeout_d;
  logic              data_s;

  assign data_s = dat_sync_q[1];

  // Clock filter: the filtered level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    fclk_d   = fclk_q;
    fcnt_d   = FCNT_W'(0);
    strobe_d = 1'b0;
    if (clk_sync_q[1] != fclk_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        fclk_d   = ~fclk_q;
        strobe_d = fclk_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end else begin
      fcnt_d = FCNT_W'(0);
    end
  end

  // Frame FSM, one step per strobe; a stalled frame times out back to idle.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_cnt_d     = to_cnt_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    timeout_d    = 1'b0;
    if (strobe_q) begin
      to_cnt_d = TO_W'(0);
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_s && odd_parity_ok(shift_q, par_q)) begin
            byte_d       = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = ST_IDLE;
        to_cnt_d    = TO_W'(0);
        frame_err_d = 1'b1;
        timeout_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = TO_W'(0);
    end
  end

  // State registers for synchroniser, filter and frame FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      fclk_q       <= 1'b1;
      fcnt_q       <= FCNT_W'(0);
      strobe_q     <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= TO_W'(0);
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q   <= {dat_sync_q[0], ps2_data_i};
      fclk_q       <= fclk_d;
      fcnt_q       <= fcnt_d;
      strobe_q     <= strobe_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign timeout_o    = timeout_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code decoder: turns received bytes into one key_valid pulse per make
// code, tracking E0/F0 prefixes and swallowing the Pause sequence.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_extended,
  output logic       frame_err
);

  logic [7:0] byte_s;
  logic       byte_valid_s;
  logic       timeout_s;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic [7:0] code_q, code_d;
  logic       kext_q, kext_d;
  logic       kvalid_q, kvalid_d;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_o      (byte_s),
    .byte_valid_o(byte_valid_s),
    .frame_err_o (frame_err),
    .timeout_o   (timeout_s)
  );

  // Prefix tracking and make-code acceptance; skip_q swallows the tail of a Pause sequence.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    code_d   = code_q;
    kext_d   = kext_q;
    kvalid_d = 1'b0;
    if (timeout_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_s) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (byte_s)
          PS2_PAUSE: skip_d = 3'd7;
          PS2_EXT:   ext_d  = 1'b1;
          PS2_BRK:   brk_d  = 1'b1;
          PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_ERR0, PS2_ERR1: kvalid_d = 1'b0;
          default: begin
            if (!brk_q) begin
              code_d   = byte_s;
              kext_d   = ext_q;
              kvalid_d = 1'b1;
            end else begin
              kvalid_d = 1'b0;
            end
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end else begin
      kvalid_d = 1'b0;
    end
  end

  // Decoder state and registered key outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= 3'd0;
      code_q   <= 8'h00;
      kext_q   <= 1'b0;
      kvalid_q <= 1'b0;
    end else begin
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
      code_q   <= code_d;
      kext_q   <= kext_d;
      kvalid_q <= kvalid_d;
    end
  end

  assign key_code     = code_q;
  assign key_extended = kext_q;
  assign key_valid    = kvalid_q;

endmodule
